// File: rtl/fpu_addsub_param_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_param_if
// Brief    : Operand/result handshake bundle for fpu_addsub_param.
// Revision : 1.0
// ============================================================================
interface fpu_addsub_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic         op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic [2:0]   flags;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output din1, din2, op, in_valid, out_ready,
        input  in_ready, result, flags, out_valid
    );

    modport slave (
        input  din1, din2, op, in_valid, out_ready,
        output in_ready, result, flags, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_param
// Brief    : Multi-cycle IEEE-754 add/subtract, RNE rounding, parametric widths.
//            Define FPU_ADDSUB_SUBNORMAL_EN for gradual underflow (else flush).
// Revision : 1.0
// ============================================================================
module fpu_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fpu_addsub_param_if.slave bus
);
    localparam int c_W   = 1 + EXP_W + MAN_W;
    localparam int c_SW  = MAN_W + 1;
    localparam int c_EXT = MAN_W + 4;
    localparam logic [31:0]      c_SHMAX = 32'(MAN_W + 3);
    localparam logic [EXP_W:0]   c_EMAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]   c_ONE_E = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] c_ONE_X = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [c_W-1:0]   c_QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           r_state;
    logic             r_in_ready, r_out_valid;
    logic [c_W-1:0]   r_result;
    logic [2:0]       r_flags;
    logic [c_W-1:0]   r_a, r_b;
    logic             r_op;
    logic             r_sa, r_sb, r_special;
    logic [EXP_W-1:0] r_ea, r_eb;
    logic [c_SW-1:0]  r_ma, r_mb;
    logic [c_W-1:0]   r_spec_res;
    logic [2:0]       r_spec_flags;
    logic             r_s, r_sub, r_zero;
    logic [EXP_W:0]   r_e, r_ne;
    logic [c_EXT-1:0] r_mx, r_my, r_nm;
    logic [c_EXT:0]   r_sum;

    // ---------------- unpack / classify ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_xa, w_xb, w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [c_SW-1:0]  w_ma, w_mb;
    logic w_a_den, w_b_den, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;

    assign w_sa     = r_a[c_W-1];
    assign w_sb     = r_b[c_W-1] ^ r_op;
    assign w_xa     = r_a[c_W-2 -: EXP_W];
    assign w_xb     = r_b[c_W-2 -: EXP_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_den  = ~|w_xa;
    assign w_b_den  = ~|w_xb;
    assign w_a_inf  = (&w_xa) & ~|w_fa;
    assign w_b_inf  = (&w_xb) & ~|w_fb;
    assign w_a_nan  = (&w_xa) & |w_fa;
    assign w_b_nan  = (&w_xb) & |w_fb;
    assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
    // Zero and subnormal both sit at effective exponent 1 so alignment is uniform.
    assign w_ea     = w_a_den ? c_ONE_X : w_xa;
    assign w_eb     = w_b_den ? c_ONE_X : w_xb;
`ifdef FPU_ADDSUB_SUBNORMAL_EN
    assign w_ma     = {~w_a_den, w_fa};
    assign w_mb     = {~w_b_den, w_fb};
`else
    assign w_ma     = w_a_den ? {c_SW{1'b0}} : {1'b1, w_fa};
    assign w_mb     = w_b_den ? {c_SW{1'b0}} : {1'b1, w_fb};
`endif

    logic           w_special;
    logic [c_W-1:0] w_spec_res;
    logic [2:0]     w_spec_flags;
    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = c_QNAN;
        w_spec_flags = 3'b000;
        if (w_a_nan || w_b_nan)
            w_spec_flags = {w_a_snan | w_b_snan, 2'b00};
        else if (w_a_inf && w_b_inf && (w_sa != w_sb))
            w_spec_flags = 3'b100;
        else if (w_a_inf)
            w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_b_inf)
            w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            w_special = 1'b0;
    end

    // ---------------- align ----------------
    logic             w_a_ge, w_lost;
    logic [EXP_W-1:0] w_ebig, w_esml, w_diff;
    logic [c_SW-1:0]  w_mbig, w_msml;
    logic [31:0]      w_sh;
    logic [c_EXT-1:0] w_ext, w_shr, w_my;

    assign w_a_ge = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_ebig = w_a_ge ? r_ea : r_eb;
    assign w_esml = w_a_ge ? r_eb : r_ea;
    assign w_mbig = w_a_ge ? r_ma : r_mb;
    assign w_msml = w_a_ge ? r_mb : r_ma;
    assign w_diff = w_ebig - w_esml;
    assign w_sh   = (32'(w_diff) > c_SHMAX) ? c_SHMAX : 32'(w_diff);
    assign w_ext  = {w_msml, 3'b000};
    assign w_shr  = w_ext >> w_sh;
    assign w_lost = |(w_ext & ~({c_EXT{1'b1}} << w_sh));
    assign w_my   = {w_shr[c_EXT-1:1], w_shr[0] | w_lost};

    // ---------------- normalise ----------------
    logic [c_EXT-1:0] w_low, w_nm;
    logic [EXP_W:0]   w_ne;
    logic [31:0]      w_lz, w_lim, w_lsh;

    assign w_low = r_sum[c_EXT-1:0];
    always_comb begin
        w_lz = 32'(c_EXT);
        for (int i = 0; i < c_EXT; i++)
            if (w_low[i]) w_lz = 32'(c_EXT - 1 - i);
    end
    // Left shift may not push the exponent below 1; the remainder stays subnormal.
    assign w_lim = 32'(r_e) - 32'd1;
    assign w_lsh = (w_lz > w_lim) ? w_lim : w_lz;
    always_comb begin
        if (r_sum[c_EXT]) begin
            w_nm = {r_sum[c_EXT:2], r_sum[1] | r_sum[0]};
            w_ne = r_e + c_ONE_E;
        end else begin
            w_nm = w_low << w_lsh;
            w_ne = r_e - (EXP_W+1)'(w_lsh);
        end
    end

    // ---------------- round / pack ----------------
    logic             w_up, w_inx, w_ovf;
    logic [MAN_W+1:0] w_mr;
    logic [c_SW-1:0]  w_mf;
    logic [EXP_W:0]   w_ef;
    logic [c_W-1:0]   w_res;
    logic [2:0]       w_flg;

    assign w_up  = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    assign w_inx = |r_nm[2:0];
    assign w_mr  = {1'b0, r_nm[c_EXT-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_mf  = w_mr[MAN_W+1] ? w_mr[MAN_W+1:1] : w_mr[MAN_W:0];
    assign w_ef  = w_mr[MAN_W+1] ? r_ne + c_ONE_E : r_ne;
    assign w_ovf = w_ef >= c_EMAX;

    always_comb begin
        w_res = {r_s, w_mf[MAN_W] ? w_ef[EXP_W-1:0] : {EXP_W{1'b0}}, w_mf[MAN_W-1:0]};
        w_flg = {2'b00, w_inx};
        if (r_special) begin
            w_res = r_spec_res;
            w_flg = r_spec_flags;
        end else if (r_zero) begin
            w_res = {~r_sub & r_s, {(c_W-1){1'b0}}};
            w_flg = 3'b000;
        end else if (w_ovf) begin
            w_res = {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 3'b011;
`ifndef FPU_ADDSUB_SUBNORMAL_EN
        end else if (!r_nm[c_EXT-1]) begin
            w_res = {r_s, {(c_W-1){1'b0}}};
            w_flg = 3'b001;
`endif
        end
    end

    // ---------------- control and pipeline registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_flags      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_ea         <= '0;
            r_eb         <= '0;
            r_ma         <= '0;
            r_mb         <= '0;
            r_special    <= 1'b0;
            r_spec_res   <= '0;
            r_spec_flags <= '0;
            r_s          <= 1'b0;
            r_sub        <= 1'b0;
            r_e          <= '0;
            r_mx         <= '0;
            r_my         <= '0;
            r_sum        <= '0;
            r_nm         <= '0;
            r_ne         <= '0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.din1;
                        r_b        <= bus.din2;
                        r_op       <= bus.op;
                        r_in_ready <= 1'b0;
                        r_state    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sa         <= w_sa;
                    r_sb         <= w_sb;
                    r_ea         <= w_ea;
                    r_eb         <= w_eb;
                    r_ma         <= w_ma;
                    r_mb         <= w_mb;
                    r_special    <= w_special;
                    r_spec_res   <= w_spec_res;
                    r_spec_flags <= w_spec_flags;
                    r_state      <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_s     <= w_a_ge ? r_sa : r_sb;
                    r_sub   <= r_sa ^ r_sb;
                    r_e     <= {1'b0, w_ebig};
                    r_mx    <= {w_mbig, 3'b000};
                    r_my    <= w_my;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                                     : ({1'b0, r_mx} + {1'b0, r_my});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_nm    <= w_nm;
                    r_ne    <= w_ne;
                    r_zero  <= ~|r_sum;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    // Result settles for one cycle before out_valid is raised.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_addsub_param
// Brief    : Directed self-checking bench for fpu_addsub_param (binary32).
// Revision : 1.0
// ============================================================================
module tb_fpu_addsub_param;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fpu_addsub_param_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation with out_ready high; check latency, result, flags, handoff.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] er, input logic [2:0] ef);
        int n   = 0;
        int lat = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.din1     = a;
        bus.din2     = b;
        bus.op       = o;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd6);
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".flags"}, {29'd0, bus.flags}, {29'd0, ef});
        @(negedge clk);
        chk({tag, ".handoff"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        bus.din1      = '0;
        bus.din2      = '0;
        bus.op        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.result", bus.result, 32'h0);
        chk("rst.flags", {29'd0, bus.flags}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel.in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        run_op("two_minus_three", 32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 3'b000);
        run_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_op("lsb_add", 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000);
        run_op("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("qnan_in", 32'h7FC00000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b000);
        run_op("snan_in", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("inf_plus_fin", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        run_op("inf_sub_flip", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run_op("cancel", 32'hC0000000, 32'h40000000, 1'b0, 32'h00000000, 3'b000);
        run_op("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_op("sub_zero_flip", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
`ifdef FPU_ADDSUB_SUBNORMAL_EN
        run_op("subnormal", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        run_op("underflow", 32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 3'b000);
`else
        run_op("subnormal", 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 3'b000);
        run_op("underflow", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
`endif

        // Backpressure with an ignored in_valid pulse while busy.
        bus.out_ready = 1'b0;
        bus.din1      = 32'h3F800000;
        bus.din2      = 32'h3F800000;
        bus.op        = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.din1      = 32'h40400000;
        bus.din2      = 32'h40400000;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp.result", bus.result, 32'h40000000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.hold_result", bus.result, 32'h40000000);
            chk("bp.hold_ctl", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        run_op("after_bp", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);

        // Reset asserted while the operation sits in ADD.
        bus.din1     = 32'h3F800000;
        bus.din2     = 32'h40000000;
        bus.op       = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst.result", bus.result, 32'h0);
        chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
